// File: rtl/counter_pkg.sv
// Shared types for the up/down event/timeout counter.
package counter_pkg;

  // Counting behaviour at a terminal value; RSVD behaves as WRAP.
  typedef enum logic [1:0] {
    WRAP    = 2'd0,
    SAT     = 2'd1,
    ONESHOT = 2'd2,
    RSVD    = 2'd3
  } mode_t;

  // Control FSM: DONE is reached only by a terminal tick in ONESHOT mode.
  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Tick divider: with en held high, tick fires once every prescale+1 cycles.
// The count freezes while en is low; clr returns it to 0 so the next enabled
// cycle ticks. prescale is sampled only when the count reloads.
module tick_prescaler #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt;

  assign tick = en && (cnt == '0);

  // Down-counter that reloads from prescale on every tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == '0) cnt <= prescale;
      else           cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/updown_counter_ovf.sv
// Parametrised up/down counter with programmable terminal value (limit),
// WRAP/SAT/ONESHOT terminal behaviour, registered overflow/underflow pulses
// and sticky flags. Optional tick prescaler under COUNTER_PRESCALE_EN.
module updown_counter_ovf
  import counter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [WIDTH-1:0]      d,
  input  logic                  up,
  input  mode_t                 mode,
  input  logic [WIDTH-1:0]      limit,
  input  logic                  clr_flags,
`ifdef COUNTER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  output logic [WIDTH-1:0]      q,
  output logic [WIDTH-1:0]      qbar,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  ovf_sticky,
  output logic                  unf_sticky,
  output logic                  done
);

  logic             tick;
  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             ovf_nxt, unf_nxt;

`ifdef COUNTER_PRESCALE_EN
  // A load restarts the prescale period so the first step after it is prompt.
  tick_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clr      (load),
    .prescale (prescale),
    .tick     (tick)
  );
`else
  assign tick = en;
`endif

  // Next count, FSM state and terminal-event detection; load beats tick.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    q_nxt     = q;
    state_nxt = state;
    ovf_nxt   = 1'b0;
    unf_nxt   = 1'b0;
    if (load) begin
      q_nxt     = d;
      state_nxt = RUN;
    end else if (tick && state == RUN) begin
      if (up) begin
        if (q < limit) begin
          q_nxt = q + 1'b1;
        end else begin
          ovf_nxt = 1'b1;
          case (mode)
            SAT:     q_nxt = limit;
            ONESHOT: begin
              q_nxt     = limit;
              state_nxt = DONE;
            end
            default: q_nxt = '0;
          endcase
        end
      end else begin
        if (q != '0) begin
          q_nxt = q - 1'b1;
        end else begin
          unf_nxt = 1'b1;
          case (mode)
            SAT:     q_nxt = q;
            ONESHOT: begin
              q_nxt     = q;
              state_nxt = DONE;
            end
            default: q_nxt = limit;
          endcase
        end
      end
    end
  end

  // Register all state and outputs; a new event outranks clr_flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q          <= '0;
      qbar       <= '1;
      state      <= RUN;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      ovf_sticky <= 1'b0;
      unf_sticky <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      q          <= q_nxt;
      qbar       <= ~q_nxt;
      state      <= state_nxt;
      overflow   <= ovf_nxt;
      underflow  <= unf_nxt;
      ovf_sticky <= ovf_nxt | (ovf_sticky & ~clr_flags);
      unf_sticky <= unf_nxt | (unf_sticky & ~clr_flags);
    end
  end

  assign done = (state == DONE);

endmodule

// File: tb/tb_updown_counter_ovf.sv
// Directed self-checking bench for updown_counter_ovf (WIDTH=8).
// Build with COUNTER_PRESCALE_EN defined to also exercise the prescaler.
module tb_updown_counter_ovf;
  import counter_pkg::*;

  localparam int WIDTH = 8;
  localparam int PW    = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en, load, up, clr_flags;
  logic [WIDTH-1:0] d, limit;
  mode_t            mode;
  logic [PW-1:0]    prescale;
  logic [WIDTH-1:0] q, qbar;
  logic             overflow, underflow, ovf_sticky, unf_sticky, done;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  updown_counter_ovf #(.WIDTH(WIDTH), .PRESCALE_W(PW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .d          (d),
    .up         (up),
    .mode       (mode),
    .limit      (limit),
    .clr_flags  (clr_flags),
`ifdef COUNTER_PRESCALE_EN
    .prescale   (prescale),
`endif
    .q          (q),
    .qbar       (qbar),
    .overflow   (overflow),
    .underflow  (underflow),
    .ovf_sticky (ovf_sticky),
    .unf_sticky (unf_sticky),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; load = 1'b0; up = 1'b1; clr_flags = 1'b0;
    d = '0; limit = 8'hFF; mode = WRAP; prescale = '0;

    // Reset held with en=1
    step(); step();
    check("rst_q", q, 8'h00);
    check("rst_qbar", qbar, 8'hFF);
    check("rst_flags", {overflow, underflow, ovf_sticky, unf_sticky, done}, 5'b0);

    // Release away from the edge; the next rising edge counts
    @(negedge clk); rst_n = 1'b1;
    step();
    check("rel_q", q, 8'h01);
    check("rel_qbar", qbar, 8'hFE);

    // WRAP up through limit=5
    en = 1'b0; limit = 8'h05; load = 1'b1; d = 8'h04;
    step();
    load = 1'b0;
    check("wrap_load_q", q, 8'h04);
    check("wrap_load_ovf", overflow, 1'b0);
    en = 1'b1;
    step();
    check("wrap_q5", q, 8'h05);
    check("wrap_q5_ovf", overflow, 1'b0);
    step();
    check("wrap_q0", q, 8'h00);
    check("wrap_ovf", overflow, 1'b1);
    check("wrap_ovf_sticky", ovf_sticky, 1'b1);
    en = 1'b0;
    step();
    check("wrap_ovf_end", overflow, 1'b0);
    check("wrap_sticky_hold", ovf_sticky, 1'b1);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    check("wrap_sticky_clr", ovf_sticky, 1'b0);

    // SAT down from 1
    mode = SAT; up = 1'b0; load = 1'b1; d = 8'h01;
    step();
    load = 1'b0; en = 1'b1;
    step();
    check("sat_q_a", q, 8'h00);
    check("sat_unf_a", underflow, 1'b0);
    step();
    check("sat_q_b", q, 8'h00);
    check("sat_unf_b", underflow, 1'b1);
    check("sat_sticky_b", unf_sticky, 1'b1);
    step();
    check("sat_q_c", q, 8'h00);
    check("sat_unf_c", underflow, 1'b1);
    en = 1'b0;
    step();
    check("sat_unf_end", underflow, 1'b0);
    check("sat_sticky_hold", unf_sticky, 1'b1);

    // ONESHOT up to limit=3
    mode = ONESHOT; up = 1'b1; limit = 8'h03; load = 1'b1; d = 8'h02;
    step();
    load = 1'b0; en = 1'b1;
    step();
    check("os_q3", q, 8'h03);
    check("os_done0", done, 1'b0);
    check("os_ovf0", overflow, 1'b0);
    step();
    check("os_q_term", q, 8'h03);
    check("os_ovf1", overflow, 1'b1);
    check("os_done1", done, 1'b1);
    step();
    check("os_frozen_q", q, 8'h03);
    check("os_frozen_ovf", overflow, 1'b0);
    check("os_frozen_done", done, 1'b1);
    step();
    check("os_frozen_q2", q, 8'h03);
    load = 1'b1; d = 8'h00;
    step();
    load = 1'b0;
    check("os_reload_done", done, 1'b0);
    check("os_reload_q", q, 8'h00);
    step();
    check("os_resume_q", q, 8'h01);

    // Boundary: q above limit after load, and set beats clear
    en = 1'b0; mode = WRAP; limit = 8'h10; load = 1'b1; d = 8'hF0; clr_flags = 1'b1;
    step();
    load = 1'b0;
    check("bnd_load_q", q, 8'hF0);
    check("bnd_load_ovf", overflow, 1'b0);
    check("bnd_sticky_clr", ovf_sticky, 1'b0);
    en = 1'b1;
    step();
    check("bnd_q", q, 8'h00);
    check("bnd_ovf", overflow, 1'b1);
    check("bnd_set_wins", ovf_sticky, 1'b1);
    clr_flags = 1'b0;

    // limit=0 in WRAP up: stays 0 and overflows every tick
    limit = 8'h00; load = 1'b1; d = 8'h00; en = 1'b0;
    step();
    load = 1'b0; en = 1'b1;
    step();
    check("lim0_q_a", q, 8'h00);
    check("lim0_ovf_a", overflow, 1'b1);
    step();
    check("lim0_q_b", q, 8'h00);
    check("lim0_ovf_b", overflow, 1'b1);

    // WRAP down at 0 goes to limit
    limit = 8'h07; up = 1'b0;
    step();
    check("wrapdn_q", q, 8'h07);
    check("wrapdn_unf", underflow, 1'b1);
    check("wrapdn_ovf", overflow, 1'b0);
    step();
    check("wrapdn_q6", q, 8'h06);
    check("wrapdn_unf_end", underflow, 1'b0);

    // Asynchronous reset mid-count
    #2 rst_n = 1'b0;
    #1;
    check("async_q", q, 8'h00);
    check("async_qbar", qbar, 8'hFF);
    check("async_flags", {overflow, underflow, ovf_sticky, unf_sticky, done}, 5'b0);
    en = 1'b0;
    @(negedge clk); rst_n = 1'b1;

`ifdef COUNTER_PRESCALE_EN
    // prescale=2: one step every 3 enabled cycles
    mode = WRAP; up = 1'b1; limit = 8'hFF; prescale = 4'd2; load = 1'b1; d = 8'h00;
    step();
    load = 1'b0; en = 1'b1;
    step(); check("ps_c1", q, 8'h01);
    step(); check("ps_c2", q, 8'h01);
    step(); check("ps_c3", q, 8'h01);
    step(); check("ps_c4", q, 8'h02);
    step(); step(); step();
    check("ps_c7", q, 8'h03);
    step(); step();
    check("ps_c9", q, 8'h03);
    step(); check("ps_c10", q, 8'h04);
    step(); check("ps_c11", q, 8'h04);
    en = 1'b0;
    step(); step(); step(); step();
    check("ps_frozen", q, 8'h04);
    en = 1'b1;
    step(); check("ps_c12", q, 8'h04);
    step(); check("ps_c13", q, 8'h05);
    en = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
